uart_rx: RTL
============

# uart_rx

UART receive stage: recovers 8N1 serial frames from the line driven by the transmit shift register and presents each received byte on a valid/ready parallel interface. The block sits directly downstream of the transmitter's serial output, either in loopback or at the far end of the link. It provides input synchronisation, mid-bit sampling, start-glitch rejection, stop-bit checking, and a single-entry output buffer with overrun detection.

## Interface
- CLKS_PER_BIT, 16, clock cycles per bit period; must be even and ≥ 4
- DATA_BITS, 8, data bits per frame, sent LSB first
- clk  input  1  sole clock; all logic is on the rising edge
- rst_n  input  1  synchronous reset, active-low, one clock
- rx  input  1  asynchronous serial line; idles high
- rx_data  output  DATA_BITS  received byte; stable while rx_valid=1
- rx_valid  output  1  rx_data holds an unconsumed byte
- rx_ready  input  1  consumer accepts the byte on a cycle where rx_valid=1 and rx_ready=1
- frame_err  output  1  one-cycle pulse: the stop bit was sampled low
- overrun  output  1  one-cycle pulse: a byte completed while the buffer was full and was dropped

## Operation
- Reset (rst_n=0 at an edge): state=IDLE, counters=0, shift register=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0. Both synchroniser flops are set to 1 (idle). Reset mid-frame abandons the frame with no error pulse.
- Synchroniser: rx passes through 2 flops to give rx_s. Only rx_s is used internally.
- Bit counter cnt has width $clog2(CLKS_PER_BIT). Bit index idx has width $clog2(DATA_BITS+1).
- FSM states and transitions:
  - IDLE: if rx_s=0, go to START and set cnt=0.
  - START: cnt increments. When cnt==CLKS_PER_BIT/2-1 at an edge, sample rx_s. If 0, go to DATA with cnt=0 and idx=0. If 1, treat as a glitch and return to IDLE with no error.
  - DATA: cnt increments. When cnt==CLKS_PER_BIT-1, sample rx_s into shift register MSB and shift right, then set cnt=0 and idx++. After DATA_BITS samples, go to STOP.
  - STOP: cnt increments. When cnt==CLKS_PER_BIT-1, sample rx_s.
    - If 1, deliver the byte and go to IDLE.
    - If 0, pulse frame_err, discard the byte, and go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Delivery, evaluated at the stop-sample edge:
  - rx_valid=0: load rx_data and set rx_valid=1.
  - rx_valid=1 and rx_ready=1 on the same cycle: old byte is consumed, new byte is loaded, rx_valid stays 1.
  - rx_valid=1 and rx_ready=0: pulse overrun, drop the new byte, keep the old byte and rx_valid.
- Consumption: rx_valid=1 and rx_ready=1 with no delivery on that edge clears rx_valid on that edge. rx_data holds its last value.
- frame_err and overrun are never asserted together. A frame with a bad stop bit never causes overrun.

## Timing
- Define edge 0 as the first edge at which rx is sampled low by synchroniser flop 1. Let H=CLKS_PER_BIT/2 and N=CLKS_PER_BIT.
- Edge 2: FSM leaves IDLE.
- Edge 2+H: start-bit midpoint check.
- Edge 2+H+(k+1)·N: data bit k is sampled, for k=0..DATA_BITS-1.
- Edge 2+H+(DATA_BITS+1)·N: stop bit is sampled; rx_valid / frame_err / overrun update on this edge.
- With defaults: midpoint at edge 10, stop sample at edge 154, rx_valid high in the cycle following edge 154.
- A new start bit is accepted 1 cycle after the stop sample (IDLE sees rx_s on the next edge). This allows back-to-back frames with a full-length stop bit.
- Throughput: 1 byte per (DATA_BITS+2)·N cycles. Consumer latency is unconstrained while no new byte completes.

## Test plan
- Reset, then send 0xA5 as an 8N1 frame at 16 clocks/bit with rx_ready=1 → rx_valid pulses 1 cycle after edge 154 with rx_data=0xA5; frame_err=0 and overrun=0 throughout.
- Send back-to-back frames 0x00, 0xFF, 0x3C with no idle gap and rx_ready held 1 → three valid handshakes delivering 0x00, 0xFF, 0x3C in order, no errors.
- Send a 3-cycle low glitch on idle rx → FSM returns to IDLE at edge 10; no rx_valid and no frame_err. Then send 0x5A → delivered correctly.
- Send 0x81 with the stop bit forced low, then hold rx low 40 cycles, then release high → one frame_err pulse at the stop sample; rx_valid stays 0; no new frame starts until rx returns high.
- With rx_ready=0, send 0x11 then 0x22 → rx_data=0x11 with rx_valid=1; overrun pulses at 0x22's stop sample; rx_data stays 0x11. Raising rx_ready then clears rx_valid.
- Drive rst_n=0 for 1 cycle during data bit 3 of a frame, then send 0xC3 → no output from the aborted frame; all outputs 0 after reset; 0xC3 delivered normally.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: parallel-side bundle of the UART receiver.
//   rx_data   : received byte, stable while rx_valid is high
//   rx_valid  : rx_data holds an unconsumed byte
//   rx_ready  : consumer accepts the byte when rx_valid && rx_ready
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, byte completed while the buffer was full
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with mid-bit sampling, start-glitch
// rejection, stop-bit checking and a single-entry output buffer.
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   rx    : asynchronous serial line, idles high
//   bus   : uart_rx_if.master (rx_data/rx_valid/rx_ready/frame_err/overrun)
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  uart_rx_if.master   bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 rx_s;
  logic                 deliver_s;

  assign rx_s = sync2_q;

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

  // Next-state logic: synchroniser, frame FSM and output buffer.
  always_comb begin
    sync1_d     = rx;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // Re-check the line half a bit in; a high level means the falling
        // edge was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d = CNT_ZERO;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = IDX_ZERO;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          // LSB arrives first, so shifting right in from the MSB leaves
          // bit 0 in position 0 after the last sample.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = CNT_ZERO;
          idx_d   = idx_q + IDX_ONE;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = CNT_ZERO;
          if (rx_s) begin
            state_d   = IDLE;
            deliver_s = 1'b1;
          end else begin
            state_d     = BRK;
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BRK: begin
        // Hold off until the line returns high so a stuck-low line does
        // not keep generating frames.
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = BRK;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // A consume on the delivery edge frees the slot for the new byte.
    if (deliver_s) begin
      if (!rx_valid_q || bus.rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // State register with synchronous active-low reset; synchroniser idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      idx_q       <= IDX_ZERO;
      shift_q     <= {DATA_BITS{1'b0}};
      rx_data_q   <= {DATA_BITS{1'b0}};
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule
